// File: rtl/alu_operand_stage_pkg.sv
// Shared definitions for the ALU operand stage: datapath width defaults and ALU control codes.
// The optional write-back bypass is selected with the WB_BYPASS_EN macro (see mips_regfile).
package alu_operand_stage_pkg;

    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_REG_ADDR_W = 5;
    localparam int unsigned DEF_IMM_W      = 16;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

endpackage

// File: rtl/alu_operand_stage_regfile.sv
// MIPS register file: two combinational read ports, one write port, hardwired zero register.
// Build option WB_BYPASS_EN: reads of the index being written return the incoming write data.
module mips_regfile
    import alu_operand_stage_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0]     rs_data,
    output logic [DATA_W-1:0]     rt_data,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data
);

    localparam int unsigned NREGS = 1 << REG_ADDR_W;

    logic [DATA_W-1:0] mem [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wb_en && (wb_addr != '0)) begin
            mem[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        rs_data = '0;
        if (rs_addr != '0) begin
`ifdef WB_BYPASS_EN
            if (wb_en && (wb_addr == rs_addr)) begin
                rs_data = wb_data;
            end else begin
                rs_data = mem[rs_addr];
            end
`else
            rs_data = mem[rs_addr];
`endif
        end
    end

    always_comb begin
        rt_data = '0;
        if (rt_addr != '0) begin
`ifdef WB_BYPASS_EN
            if (wb_en && (wb_addr == rt_addr)) begin
                rt_data = wb_data;
            end else begin
                rt_data = mem[rt_addr];
            end
`else
            rt_data = mem[rt_addr];
`endif
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Decode-side operand formation and ID/EX stage register feeding the ALU inputs directly.
// WB_BYPASS_EN (optional) enables write-through on the register file read ports.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int unsigned IMM_W      = DEF_IMM_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_dst,
    input  logic [IMM_W-1:0]      id_imm,
    input  logic                  id_imm_zext,
    input  logic                  id_alu_src,
    input  logic [3:0]            id_ctrl,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  ex_valid,
    output logic [DATA_W-1:0]     ex_a,
    output logic [DATA_W-1:0]     ex_b,
    output logic [3:0]            ex_ctrl,
    output logic [DATA_W-1:0]     ex_store_data,
    output logic [REG_ADDR_W-1:0] ex_dst
);

    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] b_sel;
    logic              imm_fill;

    mips_regfile #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .rs_addr (id_rs),
        .rt_addr (id_rt),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data)
    );

    always_comb begin
        imm_fill = id_imm[IMM_W-1] & ~id_imm_zext;
        imm_ext  = {{(DATA_W-IMM_W){imm_fill}}, id_imm};
        b_sel    = id_alu_src ? imm_ext : rt_data;
    end

    // Priority flush > stall > load; bubbles still load data so outputs stay deterministic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid      <= 1'b0;
            ex_a          <= '0;
            ex_b          <= '0;
            ex_ctrl       <= ALU_AND;
            ex_store_data <= '0;
            ex_dst        <= '0;
        end else if (flush) begin
            ex_valid      <= 1'b0;
            ex_a          <= '0;
            ex_b          <= '0;
            ex_ctrl       <= ALU_AND;
            ex_store_data <= '0;
            ex_dst        <= '0;
        end else if (!stall) begin
            ex_valid      <= id_valid;
            ex_a          <= rs_data;
            ex_b          <= b_sel;
            ex_ctrl       <= id_ctrl;
            ex_store_data <= rt_data;
            ex_dst        <= id_dst;
        end
    end

endmodule
